game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// Breakout-style game controller: serve/play/lose/win sequencing, ball motion,
// brick bookkeeping, score and lives. Every output is driven straight from a register.
module game_state_ctrl #(
    parameter int NUM_BRICKS = 6,
    parameter int LOST_HOLD  = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic [8:0]            paddle_x,
    input  logic [NUM_BRICKS-1:0] hit,
    input  logic [3:0]            dx,
    input  logic [3:0]            dy,
    output logic [8:0]            ball_x,
    output logic [8:0]            ball_y,
    output logic [NUM_BRICKS-1:0] brick_alive,
    output logic [7:0]            score,
    output logic [1:0]            lives,
    output logic [2:0]            state,
    output logic                  game_over,
    output logic                  win
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_WON   = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    localparam int CW = (LOST_HOLD > 1) ? $clog2(LOST_HOLD) : 1;
    localparam logic [CW-1:0] LOST_LAST = CW'(LOST_HOLD - 1);

    localparam logic [8:0] RST_X   = 9'd309;
    localparam logic [8:0] SERVE_Y = 9'd430;
    localparam logic [8:0] X_MAX   = 9'd484;
    localparam logic [8:0] Y_MAX   = 9'd440;
    localparam logic [9:0] SERVE_OFS = 10'd21;

    localparam logic signed [10:0] X_MIN_S = 11'sd134;
    localparam logic signed [10:0] X_MAX_S = 11'sd484;
    localparam logic signed [10:0] Y_MIN_S = 11'sd0;
    localparam logic signed [10:0] Y_MAX_S = 11'sd440;

    state_e                  state_q, state_d;
    logic                    start_q;
    logic [8:0]              ball_x_q, ball_x_d;
    logic [8:0]              ball_y_q, ball_y_d;
    logic [NUM_BRICKS-1:0]   alive_q, alive_d;
    logic [7:0]              score_q, score_d;
    logic [1:0]              lives_q, lives_d;
    logic [CW-1:0]           lost_cnt_q, lost_cnt_d;
    logic                    game_over_q, game_over_d;
    logic                    win_q, win_d;

    logic                    start_edge;
    logic [9:0]              sx_sum;
    logic [8:0]              serve_x;
    logic signed [10:0]      x_sum, y_sum;
    logic [8:0]              play_x, play_y;
    logic                    miss;
    logic [NUM_BRICKS-1:0]   alive_after, newly_hit;
    logic [8:0]              hit_count;
    logic [9:0]              score_sum;
    logic [7:0]              score_after;

    function automatic logic [8:0] popcount(input logic [NUM_BRICKS-1:0] v);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            c = c + {8'd0, v[i]};
        end
        return c;
    endfunction

    assign start_edge = start & ~start_q;

    // Serve position tracks the paddle centre, held inside the right wall.
    always_comb begin
        sx_sum  = {1'b0, paddle_x} + SERVE_OFS;
        serve_x = (sx_sum > {1'b0, X_MAX}) ? X_MAX : sx_sum[8:0];
    end

    // Sums are widened to 11-bit signed so clamping never sees a wrapped value.
    always_comb begin
        x_sum = $signed({2'b00, ball_x_q}) + $signed({{7{dx[3]}}, dx});
        y_sum = $signed({2'b00, ball_y_q}) + $signed({{7{dy[3]}}, dy});

        if (x_sum < X_MIN_S) begin
            play_x = X_MIN_S[8:0];
        end else if (x_sum > X_MAX_S) begin
            play_x = X_MAX;
        end else begin
            play_x = x_sum[8:0];
        end

        if (y_sum < Y_MIN_S) begin
            play_y = Y_MIN_S[8:0];
        end else if (y_sum > Y_MAX_S) begin
            play_y = Y_MAX;
        end else begin
            play_y = y_sum[8:0];
        end

        miss = frame_tick && (play_y == Y_MAX);
    end

    always_comb begin
        newly_hit   = alive_q & hit;
        alive_after = alive_q & ~hit;
        hit_count   = popcount(newly_hit);
        score_sum   = {2'b00, score_q} + {1'b0, hit_count};
        score_after = (score_sum > 10'd255) ? 8'd255 : score_sum[7:0];
    end

    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        alive_d    = alive_q;
        score_d    = score_q;
        lives_d    = lives_q;
        lost_cnt_d = lost_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_SERVE;
                    score_d = 8'd0;
                    lives_d = 2'd3;
                    alive_d = '1;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    ball_x_d = serve_x;
                    ball_y_d = SERVE_Y;
                end
                if (start_edge) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                alive_d = alive_after;
                score_d = score_after;
                if (frame_tick) begin
                    ball_x_d = play_x;
                    ball_y_d = play_y;
                end
                // Clearing the last brick outranks a simultaneous miss.
                if (alive_after == '0) begin
                    state_d = S_WON;
                end else if (miss) begin
                    if (lives_q <= 2'd1) begin
                        state_d = S_OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = S_LOST;
                        lives_d = lives_q - 2'd1;
                    end
                end
            end
            S_LOST: begin
                if (frame_tick) begin
                    if (lost_cnt_q == LOST_LAST) begin
                        lost_cnt_d = '0;
                        state_d    = S_SERVE;
                    end else begin
                        lost_cnt_d = lost_cnt_q + CW'(1);
                    end
                end
            end
            S_WON, S_OVER: begin
                if (start_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        game_over_d = (state_d == S_OVER);
        win_d       = (state_d == S_WON);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            ball_x_q    <= RST_X;
            ball_y_q    <= SERVE_Y;
            alive_q     <= '1;
            score_q     <= 8'd0;
            lives_q     <= 2'd3;
            lost_cnt_q  <= '0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            alive_q     <= alive_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            lost_cnt_q  <= lost_cnt_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign brick_alive = alive_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign state       = state_q;
    assign game_over   = game_over_q;
    assign win         = win_q;

endmodule
